// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion, flush and hold.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating bubble counter output.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ID_EX_valid,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [4:0]        ID_EX_RS1,
  output logic [4:0]        ID_EX_RS2,
  output logic [4:0]        ID_EX_rd,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemRead,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic              pc_write,
  output logic              if_id_write
);

  logic lu;
  logic bubble;

  // A load in EX whose rd is read by the instruction in ID must wait one cycle.
  assign lu = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 5'd0) & id_valid &
              ((id_rs1_used & (id_rs1 == ID_EX_rd)) | (id_rs2_used & (id_rs2 == ID_EX_rd)));

  assign bubble      = flush_i | lu;
  assign pc_write    = ~(lu & ~flush_i) & ~hold_i;
  assign if_id_write = ~(lu & ~flush_i) & ~hold_i;

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID_EX_valid    <= 1'b0;
      ID_EX_pc       <= '0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_imm      <= '0;
      ID_EX_RS1      <= 5'd0;
      ID_EX_RS2      <= 5'd0;
      ID_EX_rd       <= 5'd0;
      ID_EX_RegWrite <= 1'b0;
      ID_EX_MemRead  <= 1'b0;
      ID_EX_ctrl     <= '0;
    end else if (!hold_i) begin
      if (bubble) begin
        // Zeroed indices guarantee no forwarding match; ctrl 0 is side-effect free.
        ID_EX_valid    <= 1'b0;
        ID_EX_pc       <= '0;
        ID_EX_rs1_data <= '0;
        ID_EX_rs2_data <= '0;
        ID_EX_imm      <= '0;
        ID_EX_RS1      <= 5'd0;
        ID_EX_RS2      <= 5'd0;
        ID_EX_rd       <= 5'd0;
        ID_EX_RegWrite <= 1'b0;
        ID_EX_MemRead  <= 1'b0;
        ID_EX_ctrl     <= '0;
      end else begin
        ID_EX_valid    <= id_valid;
        ID_EX_pc       <= id_pc;
        ID_EX_rs1_data <= id_rs1_data;
        ID_EX_rs2_data <= id_rs2_data;
        ID_EX_imm      <= id_imm;
        ID_EX_RS1      <= id_rs1;
        ID_EX_RS2      <= id_rs2;
        ID_EX_rd       <= id_rd;
        ID_EX_RegWrite <= id_regwrite & id_valid;
        ID_EX_MemRead  <= id_memread & id_valid;
        ID_EX_ctrl     <= id_ctrl;
      end
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 32'd0;
    end else if (!hold_i && bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
